// File: rtl/serial_sub_ctrl.sv
// -----------------------------------------------------------------------------
// serial_sub_ctrl
//   Bit-serial subtraction controller. Computes diff = a - b - bin (mod 2^WIDTH)
//   and the final borrow by running one full-subtract cell (two half-subtractor
//   stages) over WIDTH cycles, LSB first, behind a start/ready/done handshake.
//
// Ports
//   clk    : rising-edge clock
//   rst    : synchronous, active-high reset
//   start  : request, accepted only on an edge where ready=1
//   a, b   : minuend / subtrahend, sampled on the accepting edge only
//   bin    : borrow-in, sampled on the accepting edge only
//   ready  : high in IDLE only
//   busy   : high in RUN only
//   done   : one-cycle pulse in DONE
//   diff   : result, held from DONE until the next accepted start
//   borrow : final borrow-out, held with diff
// -----------------------------------------------------------------------------
module serial_sub_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             ready,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_DONE = 2'b10
    } state_t;

    state_t           state_r;
    logic [WIDTH-1:0] a_r;
    logic [WIDTH-1:0] b_r;
    logic             br_r;
    logic [CW-1:0]    cnt_r;
    logic [WIDTH-1:0] res_r;

    logic [1:0]       cell_s;      // {borrow_out, difference_bit}
    logic [WIDTH-1:0] res_next_s;

    // One full-subtract cell built from two half-subtractor stages.
    function automatic logic [1:0] full_sub(input logic ai, input logic bi, input logic bri);
        logic h1_d;
        logic h1_b;
        logic h2_d;
        logic h2_b;
        h1_d = ai ^ bi;
        h1_b = ~ai & bi;
        h2_d = h1_d ^ bri;
        h2_b = ~h1_d & bri;
        return {h1_b | h2_b, h2_d};
    endfunction

    // Current-bit subtract and the result word after shifting the new bit in at the MSB.
    always_comb begin
        cell_s     = full_sub(a_r[0], b_r[0], br_r);
        res_next_s = {cell_s[0], res_r[WIDTH-1:1]};
    end

    // Control FSM, operand/result shifting and registered handshake outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
            a_r     <= {WIDTH{1'b0}};
            b_r     <= {WIDTH{1'b0}};
            br_r    <= 1'b0;
            cnt_r   <= {CW{1'b0}};
            res_r   <= {WIDTH{1'b0}};
            ready   <= 1'b1;
            busy    <= 1'b0;
            done    <= 1'b0;
            diff    <= {WIDTH{1'b0}};
            borrow  <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (start) begin
                        a_r     <= a;
                        b_r     <= b;
                        br_r    <= bin;
                        cnt_r   <= {CW{1'b0}};
                        res_r   <= {WIDTH{1'b0}};
                        state_r <= ST_RUN;
                        ready   <= 1'b0;
                        busy    <= 1'b1;
                    end else begin
                        state_r <= ST_IDLE;
                        ready   <= 1'b1;
                        busy    <= 1'b0;
                    end
                    done <= 1'b0;
                end
                ST_RUN: begin
                    a_r   <= {1'b0, a_r[WIDTH-1:1]};
                    b_r   <= {1'b0, b_r[WIDTH-1:1]};
                    br_r  <= cell_s[1];
                    res_r <= res_next_s;
                    cnt_r <= cnt_r + CNT_ONE;
                    if (cnt_r == CNT_LAST) begin
                        // Last bit: publish the full word and the final borrow.
                        state_r <= ST_DONE;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        diff    <= res_next_s;
                        borrow  <= cell_s[1];
                    end else begin
                        state_r <= ST_RUN;
                        busy    <= 1'b1;
                        done    <= 1'b0;
                    end
                    ready <= 1'b0;
                end
                ST_DONE: begin
                    // start is not looked at here, so nothing gets queued.
                    state_r <= ST_IDLE;
                    done    <= 1'b0;
                    busy    <= 1'b0;
                    ready   <= 1'b1;
                end
                default: begin
                    state_r <= ST_IDLE;
                    done    <= 1'b0;
                    busy    <= 1'b0;
                    ready   <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_sub_ctrl.sv
module tb_serial_sub_ctrl;

    localparam int WIDTH = 8;

    logic             clk;
    logic             rst;
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             bin;
    logic             ready;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] diff;
    logic             borrow;

    int n_vec = 0;
    int n_err = 0;

    serial_sub_ctrl #(.WIDTH(WIDTH)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .a      (a),
        .b      (b),
        .bin    (bin),
        .ready  (ready),
        .busy   (busy),
        .done   (done),
        .diff   (diff),
        .borrow (borrow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reset held for two edges; leaves the bench at a negedge with rst low.
    task automatic test_reset();
        rst = 1'b1; start = 1'b0; a = 8'h00; b = 8'h00; bin = 1'b0;
        repeat (2) @(negedge clk);
        n_vec++; if (ready !== 1'b1) begin n_err++; $display("FAIL reset_ready got=%b exp=1", ready); end
        n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got=%b exp=0", busy); end
        n_vec++; if (done !== 1'b0) begin n_err++; $display("FAIL reset_done got=%b exp=0", done); end
        n_vec++; if (diff !== 8'h00) begin n_err++; $display("FAIL reset_diff got=%h exp=00", diff); end
        n_vec++; if (borrow !== 1'b0) begin n_err++; $display("FAIL reset_borrow got=%b exp=0", borrow); end
        rst = 1'b0;
        @(negedge clk);
    endtask

    // One operation at minimum spacing. Entered and left right after a negedge with ready=1.
    task automatic do_op(input logic [7:0] ta, input logic [7:0] tb, input logic tbin,
                         input logic [7:0] ediff, input logic eborrow, input string name);
        int cyc;
        int busy_cnt;
        bit got;
        n_vec++; if (ready !== 1'b1) begin n_err++; $display("FAIL %s ready_pre got=%b exp=1", name, ready); end
        a = ta; b = tb; bin = tbin; start = 1'b1;
        @(negedge clk);
        start = 1'b0; a = ~ta; b = ~tb; bin = ~tbin;   // inputs are don't-care during RUN
        cyc = 1; busy_cnt = 0; got = 1'b0;
        while (!got && cyc < 20) begin
            if (done === 1'b1) got = 1'b1;
            else begin
                if (busy === 1'b1) busy_cnt++;
                @(negedge clk);
                cyc++;
            end
        end
        n_vec++; if (!got || cyc != WIDTH + 1) begin n_err++; $display("FAIL %s done_latency got=%0d exp=%0d", name, cyc, WIDTH + 1); end
        n_vec++; if (busy_cnt != WIDTH) begin n_err++; $display("FAIL %s busy_cycles got=%0d exp=%0d", name, busy_cnt, WIDTH); end
        n_vec++; if (diff !== ediff) begin n_err++; $display("FAIL %s diff got=%h exp=%h", name, diff, ediff); end
        n_vec++; if (borrow !== eborrow) begin n_err++; $display("FAIL %s borrow got=%b exp=%b", name, borrow, eborrow); end
        n_vec++; if (ready !== 1'b0 || busy !== 1'b0) begin n_err++; $display("FAIL %s done_state ready=%b busy=%b exp=0/0", name, ready, busy); end
        @(negedge clk);
        n_vec++; if (done !== 1'b0 || ready !== 1'b1) begin n_err++; $display("FAIL %s post_done done=%b ready=%b exp=0/1", name, done, ready); end
    endtask

    task automatic test_basic();
        do_op(8'd9,   8'd5,   1'b0, 8'h04, 1'b0, "sub_9_5");
        do_op(8'd5,   8'd9,   1'b0, 8'hFC, 1'b1, "sub_5_9");
        do_op(8'd0,   8'd0,   1'b1, 8'hFF, 1'b1, "zero_bin");
        do_op(8'hFF,  8'h00,  1'b0, 8'hFF, 1'b0, "max_minus_0");
        do_op(8'hA5,  8'hA5,  1'b0, 8'h00, 1'b0, "equal");
        do_op(8'h80,  8'h01,  1'b1, 8'h7E, 1'b0, "msb_bin");
    endtask

    // Result must hold while idle.
    task automatic test_hold();
        do_op(8'd5, 8'd9, 1'b0, 8'hFC, 1'b1, "hold_setup");
        repeat (3) @(negedge clk);
        n_vec++; if (diff !== 8'hFC || borrow !== 1'b1) begin n_err++; $display("FAIL hold diff=%h borrow=%b exp=fc/1", diff, borrow); end
    endtask

    // start held high during RUN and DONE must not spawn a second operation.
    task automatic test_ignore_start();
        int cyc;
        int dones;
        bit got;
        a = 8'd200; b = 8'd100; bin = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        a = 8'd1; b = 8'd2; start = 1'b1;
        cyc = 3; dones = 0; got = 1'b0;
        while (!got && cyc < 20) begin
            if (done === 1'b1) got = 1'b1;
            else begin @(negedge clk); cyc++; end
        end
        n_vec++; if (!got || cyc != WIDTH + 1) begin n_err++; $display("FAIL ign_latency got=%0d exp=%0d", cyc, WIDTH + 1); end
        n_vec++; if (diff !== 8'd100 || borrow !== 1'b0) begin n_err++; $display("FAIL ign_result diff=%0d borrow=%b exp=100/0", diff, borrow); end
        n_vec++; if (ready !== 1'b0) begin n_err++; $display("FAIL ign_ready_in_done got=%b exp=0", ready); end
        if (got) dones = 1;
        start = 1'b0;
        repeat (2) begin
            @(negedge clk);
            if (done === 1'b1) dones++;
            n_vec++; if (ready !== 1'b1 || busy !== 1'b0) begin n_err++; $display("FAIL ign_no_queue ready=%b busy=%b exp=1/0", ready, busy); end
        end
        n_vec++; if (dones != 1) begin n_err++; $display("FAIL ign_done_count got=%0d exp=1", dones); end
    endtask

    // Reset mid-RUN discards the partial result.
    task automatic test_reset_mid_run();
        int dones;
        a = 8'd50; b = 8'd20; bin = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        n_vec++; if (ready !== 1'b1 || busy !== 1'b0 || done !== 1'b0) begin n_err++; $display("FAIL rst_run ctrl ready=%b busy=%b done=%b exp=1/0/0", ready, busy, done); end
        n_vec++; if (diff !== 8'h00 || borrow !== 1'b0) begin n_err++; $display("FAIL rst_run result diff=%h borrow=%b exp=00/0", diff, borrow); end
        rst = 1'b0;
        dones = 0;
        repeat (15) begin
            @(negedge clk);
            if (done === 1'b1) dones++;
        end
        n_vec++; if (dones != 0 || diff !== 8'h00) begin n_err++; $display("FAIL rst_run no_done dones=%0d diff=%h exp=0/00", dones, diff); end
    endtask

    // Reduced operand grid (multiples of 17 cover 0 and 255) against a 9-bit reference.
    task automatic test_sweep();
        logic [8:0] exp9;
        logic [7:0] ta;
        logic [7:0] tb;
        for (int i = 0; i < 16; i++) begin
            for (int j = 0; j < 16; j++) begin
                for (int k = 0; k < 2; k++) begin
                    ta = 8'(i * 17);
                    tb = 8'(j * 17);
                    exp9 = {1'b0, ta} - {1'b0, tb} - 9'(k);
                    do_op(ta, tb, k[0], exp9[7:0], exp9[8], "sweep");
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_hold();
        test_ignore_start();
        test_reset_mid_run();
        test_sweep();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
